// File: rtl/z80_io_fabric.sv
// z80_io_fabric: Z80 I/O and memory decode, CPU read-data mux and optional
// per-device I/O wait-state generator.
//
// Build macro: IO_WAIT_STATES_EN. When it is defined, the wait FSM and its
// counter are built. When it is undefined, wait_n is tied to 1 and WS_TABLE
// is ignored.
//
// Parameters:
//   N_DEV     number of I/O devices (1..16); device k decodes at a[7:4]==k
//   WS_TABLE  4-bit wait-state count per device, device k at [4k+3:4k]
//   IACK_DEV  device whose dev_dout supplies the interrupt vector
// Ports:
//   sys_clock  system clock, rising edge
//   RESET      synchronous, active-high reset
//   cpu_ena    Z80 clock enable; the wait FSM advances only on enabled edges
//   a          CPU address bus
//   iorq_n, mreq_n, rd_n, wr_n, m1_n   Z80 bus strobes, active-low
//   dev_dout   device read data, device k at [8k+7:8k]
//   ram_dout   memory read data
//   dev_sel    registered one-hot device select
//   ram_sel    registered memory select, a[15]=1
//   rom_sel    registered memory select, a[15]=0
//   cpu_din    registered CPU read data
//   wait_n     CPU wait request, active-low
module z80_io_fabric #(
  parameter int unsigned N_DEV    = 5,
  parameter logic [63:0] WS_TABLE = '0,
  parameter int unsigned IACK_DEV = 1
) (
  input  logic               sys_clock,
  input  logic               RESET,
  input  logic               cpu_ena,
  input  logic [15:0]        a,
  input  logic               iorq_n,
  input  logic               mreq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic [8*N_DEV-1:0] dev_dout,
  input  logic [7:0]         ram_dout,
  output logic [N_DEV-1:0]   dev_sel,
  output logic               ram_sel,
  output logic               rom_sel,
  output logic [7:0]         cpu_din,
  output logic               wait_n
);

  localparam int unsigned IDXW = 4;

  logic [IDXW-1:0]  port_idx;
  logic             mapped;
  logic             io_cyc;
  logic [N_DEV-1:0] dev_sel_nxt;
  logic [7:0]       dev_rd;
  logic [7:0]       din_nxt;

  assign port_idx = a[7:4];
  assign mapped   = {1'b0, port_idx} < 5'(N_DEV);
  assign io_cyc   = ~iorq_n & mreq_n & m1_n;

  // One-hot device decode of the current bus cycle
  always_comb begin
    dev_sel_nxt = '0;
    for (int k = 0; k < int'(N_DEV); k++) begin
      dev_sel_nxt[k] = (port_idx == 4'(k)) & io_cyc;
    end
  end

  // Device read data steered by the registered select
  always_comb begin
    dev_rd = '0;
    for (int k = 0; k < int'(N_DEV); k++) begin
      if (dev_sel[k]) dev_rd = dev_rd | dev_dout[8*k +: 8];
    end
  end

  // Read mux: interrupt vector, then memory, then I/O; otherwise hold
  always_comb begin
    din_nxt = cpu_din;
    if (!iorq_n && !m1_n)       din_nxt = dev_dout[8*IACK_DEV +: 8];
    else if (!rd_n && !mreq_n)  din_nxt = ram_dout;
    else if (!rd_n && !iorq_n)  din_nxt = mapped ? dev_rd : a[7:0];
  end

  // Decode and read-data registers
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      dev_sel <= '0;
      ram_sel <= 1'b0;
      rom_sel <= 1'b0;
      cpu_din <= 8'hFF;
    end else begin
      dev_sel <= dev_sel_nxt;
      ram_sel <= a[15] & ~mreq_n;
      rom_sel <= ~a[15] & ~mreq_n;
      cpu_din <= din_nxt;
    end
  end

`ifdef IO_WAIT_STATES_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } wait_state_t;

  wait_state_t     state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            wait_nxt;
  logic [3:0]      ws_entry;

  // Unmapped ports take no wait states
  assign ws_entry = mapped ? WS_TABLE[{port_idx, 2'b00} +: 4] : 4'd0;

  // Wait FSM state, counter and wait_n registers
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wait_n <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wait_n <= wait_nxt;
    end
  end

  // One wait sequence per I/O cycle; HOLD blocks a reload until iorq_n rises
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_n;
    if (cpu_ena) begin
      case (state)
        IDLE: begin
          if (!iorq_n && m1_n) begin
            cnt_nxt = ws_entry;
            if (ws_entry != 4'd0) begin
              wait_nxt  = 1'b0;
              state_nxt = COUNT;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        COUNT: begin
          if (iorq_n) begin
            cnt_nxt   = 4'd0;
            wait_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (cnt == 4'd1) begin
            cnt_nxt   = 4'd0;
            wait_nxt  = 1'b1;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        HOLD: begin
          if (iorq_n) state_nxt = IDLE;
        end
        default: begin
          cnt_nxt   = 4'd0;
          wait_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wr_n, a[14:8]};
`else
  localparam logic unused_ws = ^WS_TABLE;

  assign wait_n = 1'b1;

  logic unused_ok;
  assign unused_ok = &{1'b0, wr_n, a[14:8], cpu_ena, unused_ws};
`endif

endmodule

// File: doc/z80_io_fabric.md
Z80_IO_FABRIC -- requirements
Module: z80_io_fabric

Interface
REQ-001 The block SHALL have parameter N_DEV, default 5, meaning the number of I/O devices, legal range 1..16.
REQ-002 The block SHALL have parameter WS_TABLE, default 0, meaning the wait states for each device, 4 bits per device, device k at bits [4k+3:4k].
REQ-003 The block SHALL have parameter IACK_DEV, default 1, meaning the index of the device that supplies the interrupt vector.
REQ-004 sys_clock  in  1  system clock; every flop is clocked on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 cpu_ena  in  1  Z80 clock enable.
REQ-007 a  in  16  CPU address bus.
REQ-008 iorq_n, mreq_n, rd_n, wr_n, m1_n  in  1 each  Z80 bus strobes, active-low.
REQ-009 dev_dout  in  8*N_DEV  device read data; device k at bits [8k+7:8k].
REQ-010 ram_dout  in  8  memory read data.
REQ-011 dev_sel  out  N_DEV  registered one-hot device select.
REQ-012 ram_sel  out  1  memory access with a[15]=1.
REQ-013 rom_sel  out  1  memory access with a[15]=0.
REQ-014 cpu_din  out  8  registered CPU read data.
REQ-015 wait_n  out  1  CPU wait request, active-low.

Function
REQ-016 Each sys_clock edge, dev_sel[k] SHALL register (a[7:4]==k) & ~iorq_n & mreq_n & m1_n, for k < N_DEV.
REQ-017 An I/O cycle with a[7:4] >= N_DEV SHALL be unmapped: no dev_sel bit set, zero wait states.
REQ-018 Each edge, ram_sel SHALL register a[15] & ~mreq_n, and rom_sel SHALL register ~a[15] & ~mreq_n.
REQ-019 cpu_din SHALL be updated by this priority, highest first:
- iorq_n=0 & m1_n=0 (interrupt acknowledge): dev_dout[IACK_DEV].
- rd_n=0 & mreq_n=0: ram_dout.
- rd_n=0 & iorq_n=0: the selected device's dev_dout; if unmapped, a[7:0].
REQ-020 If none of the REQ-019 conditions holds, cpu_din SHALL hold its value.
REQ-021 cpu_din SHALL have 1 sys_clock latency from the selected device (registered dev_sel feeding the mux).
REQ-022 The wait FSM SHALL have states IDLE, COUNT and HOLD, and SHALL advance only when cpu_ena=1.
REQ-023 IDLE: when iorq_n=0 and m1_n=1, the 4-bit counter SHALL load the WS_TABLE entry of the decoded device.
- Entry nonzero: wait_n<=0, go to COUNT.
- Entry zero: go to HOLD.
REQ-024 COUNT: the counter SHALL decrement once per cpu_ena; on reaching 0, wait_n<=1 and go to HOLD.
REQ-025 HOLD: the FSM SHALL stay until iorq_n=1, then go to IDLE; this gives exactly one wait sequence per I/O cycle.
REQ-026 If iorq_n=1 while in COUNT (abort), the FSM SHALL set wait_n<=1 and go to IDLE on the same enabled edge.
REQ-027 Interrupt-acknowledge cycles and memory cycles SHALL never insert wait states.
REQ-028 A WS_TABLE entry of 15 SHALL yield exactly 15 cpu_ena periods with wait_n=0; the counter SHALL NOT wrap.
REQ-029 wr_n SHALL have no effect on cpu_din.

Reset
REQ-030 While RESET=1, the outputs SHALL be: dev_sel=0, ram_sel=0, rom_sel=0, cpu_din=8'hFF, wait_n=1; the FSM SHALL be IDLE and the counter 0.
REQ-031 RESET SHALL take effect regardless of cpu_ena and SHALL abort any wait sequence in progress.
REQ-032 On the first edge after RESET falls, the block SHALL decode normally.

Configuration
REQ-033 With macro IO_WAIT_STATES_EN defined, the wait FSM and counter SHALL be built as in REQ-022..REQ-028.
REQ-034 Without IO_WAIT_STATES_EN, wait_n SHALL be constant 1, WS_TABLE SHALL be ignored, and no FSM logic SHALL be generated.
REQ-035 Decode and read-mux behaviour SHALL be identical with and without the macro.

Verification
REQ-036 With N_DEV=5, an IN at port 0x32 with dev_dout[3]=0x5A SHALL give dev_sel=5'b01000, then cpu_din=0x5A one edge later.
REQ-037 An IN at port 0x7C with N_DEV=5 (unmapped) SHALL give cpu_din=0x7C and no dev_sel bit set.
REQ-038 With IO_WAIT_STATES_EN and WS_TABLE entry for device 2 = 3, an IN at port 0x20 SHALL hold wait_n=0 for exactly 3 cpu_ena pulses, then 1.
REQ-039 An interrupt acknowledge (iorq_n=0, m1_n=0) with IACK_DEV=1 and dev_dout[1]=0xE8 SHALL give cpu_din=0xE8 and wait_n stays 1.
REQ-040 RESET asserted during COUNT SHALL give wait_n=1 and cpu_din=0xFF on the next edge; a following IN at port 0x20 SHALL restart the full 3-cycle wait.
REQ-041 With a WS_TABLE entry of 15 and iorq_n released after 6 enabled cycles, wait_n SHALL rise on that edge and the FSM SHALL return to IDLE.
